// File: rtl/interrupt_ack_control_8259.sv
// interrupt_ack_control_8259: INTA acknowledge sequencer, OCW2 EOI/rotate decode and vector byte generation
module interrupt_ack_control_8259 #(
    parameter logic [7:0] CALL_OPCODE = 8'hCD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_acknowledge_n,
    input  logic        mode_8086,
    input  logic        auto_eoi,
    input  logic [4:0]  vector_base,
    input  logic [15:0] call_address,
    input  logic        address_interval_4,
    input  logic [7:0]  highest_level_in_request,
    input  logic [7:0]  highest_level_in_service,
    input  logic        write_ocw2,
    input  logic [7:0]  ocw2_data,
    output logic        latch_in_service,
    output logic [7:0]  clear_interrupt_request,
    output logic [7:0]  end_of_interrupt,
    output logic [2:0]  priority_rotate,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_out_enable,
    output logic        ack_in_progress
);
    typedef enum logic [1:0] {IDLE, ACK1, ACK2, ACK3} state_t;
    state_t state;
    logic inta_d, seq_mode, spurious, rotate_in_aeoi, fall, rise, end_seq, ocw_rot_en;
    logic [7:0] acked_level, data_byte, ocw_eoi, aeoi_mask, vector_byte;
    logic [2:0] lvl, ocw_rot, cmd;
    logic unused_ok;

    function automatic logic [2:0] encode(input logic [7:0] v);
        encode = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) encode = 3'(i);
    endfunction

    always_comb begin
        fall = inta_d & ~interrupt_acknowledge_n;
        rise = ~inta_d & interrupt_acknowledge_n;
        lvl = encode(acked_level);
        vector_byte = seq_mode ? {vector_base, lvl}
                    : address_interval_4 ? {call_address[7:5], lvl, 2'b00}
                    : {call_address[7:6], lvl, 3'b000};
        end_seq = rise & ((state == ACK2 & seq_mode) | state == ACK3);
        aeoi_mask = (end_seq & auto_eoi & ~spurious) ? acked_level : 8'h00;
        cmd = ocw2_data[7:5];
        // cmd[0] is the EOI bit, cmd[1] selects specific level, cmd[2] is rotate
        ocw_eoi = (!write_ocw2 || !cmd[0]) ? 8'h00
                : cmd[1] ? 8'd1 << ocw2_data[2:0] : highest_level_in_service;
        ocw_rot_en = write_ocw2 & cmd[2] & (cmd[1] | (cmd[0] & |highest_level_in_service));
        ocw_rot = cmd[1] ? ocw2_data[2:0] : encode(highest_level_in_service);
    end

    assign data_bus_out = data_bus_out_enable ? data_byte : 8'h00;
    assign unused_ok = ^{ocw2_data[4:3], call_address[4:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            inta_d <= 1'b0;
            seq_mode <= 1'b0;
            spurious <= 1'b0;
            acked_level <= 8'h00;
            rotate_in_aeoi <= 1'b0;
            latch_in_service <= 1'b0;
            clear_interrupt_request <= 8'h00;
            end_of_interrupt <= 8'h00;
            priority_rotate <= 3'b111;
            data_bus_out_enable <= 1'b0;
            data_byte <= 8'h00;
            ack_in_progress <= 1'b0;
        end else begin
            inta_d <= interrupt_acknowledge_n;
            latch_in_service <= 1'b0;
            clear_interrupt_request <= 8'h00;
            end_of_interrupt <= ocw_eoi | aeoi_mask;
            if (ocw_rot_en)
                priority_rotate <= ocw_rot;
            else if (|aeoi_mask && rotate_in_aeoi)
                priority_rotate <= lvl;
            if (write_ocw2 && cmd[1:0] == 2'b00)
                rotate_in_aeoi <= cmd[2];
            case (state)
                IDLE: if (fall) begin
                    state <= ACK1;
                    seq_mode <= mode_8086;
                    spurious <= ~|highest_level_in_request;
                    acked_level <= |highest_level_in_request ? highest_level_in_request : 8'h80;
                    latch_in_service <= |highest_level_in_request;
                    clear_interrupt_request <= highest_level_in_request;
                    ack_in_progress <= 1'b1;
                    data_bus_out_enable <= ~mode_8086;
                    data_byte <= CALL_OPCODE;
                end
                ACK1: begin
                    data_bus_out_enable <= ~seq_mode & ~interrupt_acknowledge_n;
                    if (rise) state <= ACK2;
                end
                ACK2: begin
                    if (fall) begin
                        data_bus_out_enable <= 1'b1;
                        data_byte <= vector_byte;
                    end
                    if (rise) begin
                        data_bus_out_enable <= 1'b0;
                        state <= seq_mode ? IDLE : ACK3;
                        ack_in_progress <= ~seq_mode;
                    end
                end
                ACK3: begin
                    if (fall) begin
                        data_bus_out_enable <= 1'b1;
                        data_byte <= call_address[15:8];
                    end
                    if (rise) begin
                        data_bus_out_enable <= 1'b0;
                        state <= IDLE;
                        ack_in_progress <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_interrupt_ack_control_8259.sv
// tb_interrupt_ack_control_8259: directed INTA/OCW2 scenarios checked against a pulse-count model every cycle
module tb_interrupt_ack_control_8259;
    logic clock = 0, reset = 1, inta_n = 1, mode_8086 = 1, auto_eoi = 0, adi = 0, write_ocw2 = 0;
    logic [4:0] vector_base = 0;
    logic [15:0] call_address = 0;
    logic [7:0] req = 0, hls = 0, ocw2_data = 0;
    logic latch_in_service, data_bus_out_enable, ack_in_progress;
    logic [7:0] clear_interrupt_request, end_of_interrupt, data_bus_out;
    logic [2:0] priority_rotate;

    interrupt_ack_control_8259 dut (
        .clock(clock), .reset(reset), .interrupt_acknowledge_n(inta_n),
        .mode_8086(mode_8086), .auto_eoi(auto_eoi), .vector_base(vector_base),
        .call_address(call_address), .address_interval_4(adi),
        .highest_level_in_request(req), .highest_level_in_service(hls),
        .write_ocw2(write_ocw2), .ocw2_data(ocw2_data),
        .latch_in_service(latch_in_service), .clear_interrupt_request(clear_interrupt_request),
        .end_of_interrupt(end_of_interrupt), .priority_rotate(priority_rotate),
        .data_bus_out(data_bus_out), .data_bus_out_enable(data_bus_out_enable),
        .ack_in_progress(ack_in_progress)
    );

    always #5 clock = ~clock;

    int tests = 0, fails = 0;
    logic run = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [2:0] pos(input logic [7:0] v);
        pos = 3'd0;
        for (int i = 0; i < 8; i++)
            if (v[i]) pos = 3'(i);
    endfunction

    // Model: a sequence is a list of per-pulse bytes; the pulse count selects what is driven.
    logic prev_n = 0, m_active = 0, m_spur = 0, m_rot_aeoi = 0, m_fall, m_rise;
    int m_pulse = 0, m_total = 0;
    logic [2:0] m_level = 0;
    logic [7:0] m_bytes [3];
    logic m_def [3];
    logic e_latch = 0, e_en = 0, e_ack = 0;
    logic [7:0] e_clr = 0, e_eoi = 0, e_bus = 0;
    logic [2:0] e_rot = 3'b111;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_n = 0; m_active = 0; m_pulse = 0; m_rot_aeoi = 0;
            e_latch = 0; e_clr = 0; e_eoi = 0; e_rot = 3'b111; e_en = 0; e_bus = 0; e_ack = 0;
        end else begin
            m_fall = prev_n & ~inta_n;
            m_rise = ~prev_n & inta_n;
            prev_n = inta_n;
            e_latch = 0; e_clr = 0; e_eoi = 0;
            if (!m_active && m_fall) begin
                m_active = 1; m_pulse = 1;
                m_spur = (req == 0);
                m_level = m_spur ? 3'd7 : pos(req);
                e_latch = !m_spur; e_clr = req;
                m_total = mode_8086 ? 2 : 3;
                m_bytes[0] = 8'hCD; m_def[0] = !mode_8086;
                m_bytes[1] = mode_8086 ? {vector_base, m_level}
                           : adi ? {call_address[7:5], m_level, 2'b00}
                           : {call_address[7:6], m_level, 3'b000};
                m_def[1] = 1;
                m_bytes[2] = call_address[15:8]; m_def[2] = 1;
            end else if (m_active && m_fall) begin
                m_pulse++;
            end else if (m_active && m_rise && m_pulse == m_total) begin
                m_active = 0;
                if (auto_eoi && !m_spur) begin
                    e_eoi = 8'd1 << m_level;
                    if (m_rot_aeoi) e_rot = m_level;
                end
            end
            if (write_ocw2)
                case (ocw2_data[7:5])
                    3'b001: e_eoi |= hls;
                    3'b011: e_eoi |= 8'd1 << ocw2_data[2:0];
                    3'b101: begin e_eoi |= hls; if (hls != 0) e_rot = pos(hls); end
                    3'b111: begin e_eoi |= 8'd1 << ocw2_data[2:0]; e_rot = ocw2_data[2:0]; end
                    3'b110: e_rot = ocw2_data[2:0];
                    3'b100: m_rot_aeoi = 1;
                    3'b000: m_rot_aeoi = 0;
                    default: ;
                endcase
            e_en = (m_active && !inta_n) ? m_def[m_pulse-1] : 1'b0;
            e_bus = e_en ? m_bytes[m_pulse-1] : 8'h00;
            e_ack = m_active;
        end
    end

    int latch_cnt = 0, clr_cnt = 0, eoi_cnt = 0;
    logic [7:0] clr_last = 0, eoi_last = 0;

    always @(negedge clock) if (run) begin
        chk("latch_in_service", {15'd0, latch_in_service}, {15'd0, e_latch});
        chk("clear_interrupt_request", {8'd0, clear_interrupt_request}, {8'd0, e_clr});
        chk("end_of_interrupt", {8'd0, end_of_interrupt}, {8'd0, e_eoi});
        chk("priority_rotate", {13'd0, priority_rotate}, {13'd0, e_rot});
        chk("data_bus_out_enable", {15'd0, data_bus_out_enable}, {15'd0, e_en});
        chk("data_bus_out", {8'd0, data_bus_out}, {8'd0, e_bus});
        chk("ack_in_progress", {15'd0, ack_in_progress}, {15'd0, e_ack});
        if (latch_in_service) latch_cnt++;
        if (|clear_interrupt_request) begin clr_cnt++; clr_last = clear_interrupt_request; end
        if (|end_of_interrupt) begin eoi_cnt++; eoi_last = end_of_interrupt; end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse(output logic [7:0] b, output logic e);
        inta_n = 0;
        tick(2);
        b = data_bus_out;
        e = data_bus_out_enable;
        tick(1);
        inta_n = 1;
        tick(3);
    endtask

    task automatic ocw(input logic [7:0] d, output logic [7:0] eo);
        write_ocw2 = 1; ocw2_data = d;
        tick(1);
        eo = end_of_interrupt;
        write_ocw2 = 0;
        tick(1);
    endtask

    logic [7:0] b, eo;
    logic e;
    int l0, c0, e0;

    initial begin
        #2 reset = 0;
        run = 1;
        tick(2);
        chk("reset_rotate", {13'd0, priority_rotate}, 16'h0007);
        chk("reset_enable", {15'd0, data_bus_out_enable}, 16'h0000);
        reset = 1;
        tick(3);

        // 8086, AEOI off
        mode_8086 = 1; vector_base = 5'h08; req = 8'h04;
        l0 = latch_cnt; c0 = clr_cnt; e0 = eoi_cnt;
        pulse(b, e);
        chk("t1_first_pulse_enable", {15'd0, e}, 16'h0000);
        chk("t1_ack_mid", {15'd0, ack_in_progress}, 16'h0001);
        pulse(b, e);
        chk("t1_vector", {8'd0, b}, 16'h0042);
        chk("t1_latch_count", 16'(latch_cnt - l0), 16'd1);
        chk("t1_clear_count", 16'(clr_cnt - c0), 16'd1);
        chk("t1_clear_value", {8'd0, clr_last}, 16'h0004);
        chk("t1_no_eoi", 16'(eoi_cnt - e0), 16'd0);
        chk("t1_ack_done", {15'd0, ack_in_progress}, 16'h0000);

        // 8080, ADI = 1 then ADI = 0
        mode_8086 = 0; call_address = 16'h12E0; adi = 1; req = 8'h20;
        pulse(b, e); chk("t2a_byte1", {8'd0, b}, 16'h00CD);
        pulse(b, e); chk("t2a_byte2", {8'd0, b}, 16'h00F4);
        pulse(b, e); chk("t2a_byte3", {8'd0, b}, 16'h0012);
        adi = 0; call_address = 16'h1200;
        pulse(b, e); chk("t2b_byte1", {8'd0, b}, 16'h00CD);
        pulse(b, e); chk("t2b_byte2", {8'd0, b}, 16'h0028);
        pulse(b, e); chk("t2b_byte3", {8'd0, b}, 16'h0012);

        // spurious
        mode_8086 = 1; vector_base = 5'h08; req = 8'h00; auto_eoi = 1;
        l0 = latch_cnt; c0 = clr_cnt; e0 = eoi_cnt;
        pulse(b, e);
        pulse(b, e);
        chk("t3_vector", {8'd0, b}, 16'h0047);
        chk("t3_no_latch", 16'(latch_cnt - l0), 16'd0);
        chk("t3_no_clear", 16'(clr_cnt - c0), 16'd0);
        chk("t3_no_eoi", 16'(eoi_cnt - e0), 16'd0);
        auto_eoi = 0;

        // OCW2 commands
        hls = 8'h10;
        ocw(8'h20, eo); chk("t4_nonspecific", {8'd0, eo}, 16'h0010);
        chk("t4_one_cycle", {8'd0, end_of_interrupt}, 16'h0000);
        ocw(8'h63, eo); chk("t4_specific", {8'd0, eo}, 16'h0008);
        ocw(8'hE5, eo); chk("t4_rot_specific", {8'd0, eo}, 16'h0020);
        chk("t4_rot_specific_level", {13'd0, priority_rotate}, 16'h0005);
        ocw(8'hC2, eo); chk("t4_set_priority_eoi", {8'd0, eo}, 16'h0000);
        chk("t4_set_priority", {13'd0, priority_rotate}, 16'h0002);
        hls = 8'h00;

        // AEOI with rotate
        ocw(8'h80, eo);
        auto_eoi = 1; mode_8086 = 1; req = 8'h02;
        e0 = eoi_cnt;
        pulse(b, e);
        pulse(b, e);
        chk("t5_aeoi_count", 16'(eoi_cnt - e0), 16'd1);
        chk("t5_aeoi_mask", {8'd0, eoi_last}, 16'h0002);
        chk("t5_aeoi_rotate", {13'd0, priority_rotate}, 16'h0001);
        pulse(b, e);
        inta_n = 0;
        tick(3);
        inta_n = 1; write_ocw2 = 1; ocw2_data = 8'h60;
        tick(1);
        write_ocw2 = 0;
        chk("t5_eoi_merge", {8'd0, end_of_interrupt}, 16'h0003);
        tick(3);
        auto_eoi = 0;

        // reset mid-sequence
        req = 8'h08;
        pulse(b, e);
        inta_n = 0;
        tick(2);
        chk("t6_driving", {7'd0, data_bus_out_enable, data_bus_out}, 16'h0143);
        reset = 0;
        #1;
        chk("t6_enable_drop", {15'd0, data_bus_out_enable}, 16'h0000);
        chk("t6_bus_zero", {8'd0, data_bus_out}, 16'h0000);
        chk("t6_rotate", {13'd0, priority_rotate}, 16'h0007);
        chk("t6_ack", {15'd0, ack_in_progress}, 16'h0000);
        tick(1);
        reset = 1;
        tick(2);
        inta_n = 1;
        tick(3);
        l0 = latch_cnt;
        pulse(b, e);
        chk("t6_fresh_latch", 16'(latch_cnt - l0), 16'd1);
        chk("t6_fresh_ack", {15'd0, ack_in_progress}, 16'h0001);
        pulse(b, e);
        chk("t6_fresh_vector", {8'd0, b}, 16'h0043);
        tick(3);
        run = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
